kick_scorer: RTL and testbench

Downstream consumer of the kick counter's 16-bit `count`. Arms on a round start, captures `count` on the player's synchronised kick press, and grades the capture against a target window. Emits one-cycle hit/miss pulses and keeps a saturating score, current streak and best streak for the display logic. It never drives the counter; `go` and `en` for the counter are generated elsewhere.

---
 rtl/kick_scorer.sv | 131 +++++++++++++
 tb/tb_kick_scorer.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/kick_scorer.sv
// Kick scorer: arms on round_start, captures the kick counter on a synchronised press and grades it.
// Optional KICK_PERFECT_EN: perfect hits (within WINDOW/4) pulse `perfect` and earn 2 points.
module kick_scorer #(
   parameter logic [15:0] TARGET   = 16'd21920,
   parameter logic [15:0] WINDOW   = 16'd2000,
   parameter logic [15:0] MAXCOUNT = 16'd43840
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] count,
   input  logic        kick,
   input  logic        round_start,
   input  logic        score_clr,
   output logic        armed,
   output logic        hit,
   output logic        miss,
   output logic        perfect,
   output logic [7:0]  score,
   output logic [3:0]  streak,
   output logic [3:0]  best_streak
);

   typedef enum logic [1:0] {IDLE, ARMED, JUDGE} state_t;

   state_t      state;
   logic        s1, s2, s3;
   logic        press;
   logic [15:0] cap;
   logic [16:0] diff;
   logic        is_hit;
   logic        is_perf;
   logic [1:0]  inc;
   logic [8:0]  score_sum;
   logic [7:0]  score_sat;
   logic [3:0]  streak_inc;
   logic [3:0]  best_next;

   assign press = s2 & ~s3;

   always_comb begin
      diff = (cap >= TARGET) ? ({1'b0, cap} - {1'b0, TARGET})
                             : ({1'b0, TARGET} - {1'b0, cap});
      is_hit = (diff <= {1'b0, WINDOW});
`ifdef KICK_PERFECT_EN
      is_perf = is_hit && (diff <= {3'b000, WINDOW[15:2]});
      inc     = is_perf ? 2'd2 : 2'd1;
`else
      is_perf = 1'b0;
      inc     = 2'd1;
`endif
      score_sum  = {1'b0, score} + {7'b0, inc};
      score_sat  = score_sum[8] ? 8'hFF : score_sum[7:0];
      streak_inc = (streak == 4'hF) ? 4'hF : streak + 4'd1;
      best_next  = (streak_inc > best_streak) ? streak_inc : best_streak;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         s1          <= 1'b0;
         s2          <= 1'b0;
         s3          <= 1'b0;
         cap         <= '0;
         armed       <= 1'b0;
         hit         <= 1'b0;
         miss        <= 1'b0;
         score       <= '0;
         streak      <= '0;
         best_streak <= '0;
      end else begin
         s1   <= kick;
         s2   <= s1;
         s3   <= s2;
         hit  <= 1'b0;
         miss <= 1'b0;
         case (state)
            IDLE: begin
               if (round_start) begin
                  state <= ARMED;
                  armed <= 1'b1;
               end
            end
            ARMED: begin
               // A press edge beats a same-cycle terminal count.
               if (press) begin
                  cap   <= count;
                  state <= JUDGE;
                  armed <= 1'b0;
               end else if (count == MAXCOUNT) begin
                  miss   <= 1'b1;
                  streak <= '0;
                  state  <= IDLE;
                  armed  <= 1'b0;
               end
            end
            JUDGE: begin
               state <= IDLE;
               if (is_hit) begin
                  hit         <= 1'b1;
                  score       <= score_sat;
                  streak      <= streak_inc;
                  best_streak <= best_next;
               end else begin
                  miss   <= 1'b1;
                  streak <= '0;
               end
            end
            default: begin
               state <= IDLE;
               armed <= 1'b0;
            end
         endcase
         // Clear overrides any same-cycle score update; pulses and state are untouched.
         if (score_clr) begin
            score       <= '0;
            streak      <= '0;
            best_streak <= '0;
         end
      end
   end

`ifdef KICK_PERFECT_EN
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) perfect <= 1'b0;
      else         perfect <= (state == JUDGE) && is_perf;
   end
`else
   assign perfect = 1'b0;
`endif

endmodule

// File: tb/tb_kick_scorer.sv
// Directed self-checking bench for kick_scorer; expected values follow KICK_PERFECT_EN if defined.
module tb_kick_scorer;

   logic        clk = 1'b0;
   logic        resetn;
   logic [15:0] count;
   logic        kick;
   logic        round_start;
   logic        score_clr;
   logic        armed, hit, miss, perfect;
   logic [7:0]  score;
   logic [3:0]  streak, best_streak;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   int exp_score  = 0;
   int exp_streak = 0;
   int exp_best   = 0;

`ifdef KICK_PERFECT_EN
   localparam bit PERF_EN = 1'b1;
`else
   localparam bit PERF_EN = 1'b0;
`endif

   kick_scorer #(
      .TARGET   (16'd21920),
      .WINDOW   (16'd2000),
      .MAXCOUNT (16'd43840)
   ) dut (
      .clk         (clk),
      .resetn      (resetn),
      .count       (count),
      .kick        (kick),
      .round_start (round_start),
      .score_clr   (score_clr),
      .armed       (armed),
      .hit         (hit),
      .miss        (miss),
      .perfect     (perfect),
      .score       (score),
      .streak      (streak),
      .best_streak (best_streak)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ".armed"},  armed, 0);
      check({tag, ".hit"},    hit, 0);
      check({tag, ".miss"},   miss, 0);
      check({tag, ".perf"},   perfect, 0);
      check({tag, ".score"},  score, 0);
      check({tag, ".streak"}, streak, 0);
      check({tag, ".best"},   best_streak, 0);
   endtask

   // Arm, kick at count c, check the graded pulse and the running totals.
   task automatic play(input logic [15:0] c, input bit eh, input bit ep, input string tag);
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      check({tag, ".armed"}, armed, 1);
      count = c;
      kick  = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      if (eh) begin
         exp_score  = exp_score + ((ep && PERF_EN) ? 2 : 1);
         if (exp_score > 255) exp_score = 255;
         exp_streak = (exp_streak == 15) ? 15 : exp_streak + 1;
         if (exp_streak > exp_best) exp_best = exp_streak;
      end else begin
         exp_streak = 0;
      end
      check({tag, ".hit"},    hit, eh);
      check({tag, ".miss"},   miss, !eh);
      check({tag, ".perf"},   perfect, ep && PERF_EN);
      check({tag, ".score"},  score, exp_score);
      check({tag, ".streak"}, streak, exp_streak);
      check({tag, ".best"},   best_streak, exp_best);
      check({tag, ".idle"},   armed, 0);
      kick = 1'b0;
      @(negedge clk);
      check({tag, ".hit1cyc"},  hit, 0);
      check({tag, ".miss1cyc"}, miss, 0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      int pulses;
      resetn = 1'b0; count = '0; kick = 1'b0; round_start = 1'b0; score_clr = 1'b0;
      repeat (2) @(negedge clk);
      check_zero("reset");
      resetn = 1'b1;
      @(negedge clk);

      play(16'd21000, 1, 0, "hit920");
      play(16'd21920, 1, 1, "perfect0");
      play(16'd23000, 1, 0, "hit1080");
      play(16'd30000, 0, 0, "miss8080");
      play(16'd23920, 1, 0, "edge_hi_in");
      play(16'd23921, 0, 0, "edge_hi_out");
      play(16'd19920, 1, 0, "edge_lo_in");
      play(16'd21420, 1, 1, "perf_edge");
      play(16'd21419, 1, 0, "perf_out");

      // Timeout: armed with no kick while count ramps to terminal.
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      count = 16'd43838;
      @(negedge clk);
      count = 16'd43839;
      @(negedge clk);
      check("to.armed_before", armed, 1);
      count = 16'd43840;
      @(negedge clk);
      check("to.miss", miss, 1);
      check("to.hit", hit, 0);
      check("to.armed", armed, 0);
      check("to.streak", streak, 0);
      check("to.score", score, exp_score);
      exp_streak = 0;
      @(negedge clk);
      check("to.miss1cyc", miss, 0);
      count = '0;
      repeat (2) @(negedge clk);

      // Press edge coincides with terminal count: judged via JUDGE, single miss.
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      count = 16'd43000;
      kick  = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      count = 16'd43840;
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (miss) pulses++;
         check("tie.nohit", hit, 0);
      end
      check("tie.miss_pulses", pulses, 1);
      check("tie.armed", armed, 0);
      kick  = 1'b0;
      count = '0;
      repeat (4) @(negedge clk);

      // score_clr in the judge cycle: pulse fires, totals cleared.
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      count = 16'd21000;
      kick  = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      score_clr = 1'b1;
      @(negedge clk);
      score_clr = 1'b0;
      check("clr.hit", hit, 1);
      check("clr.score", score, 0);
      check("clr.streak", streak, 0);
      check("clr.best", best_streak, 0);
      exp_score = 0; exp_streak = 0; exp_best = 0;
      kick = 1'b0;
      repeat (4) @(negedge clk);

      // Drive score up to 254 and the streak into saturation.
      while (exp_score < 254) play(16'd21000, 1, 0, "fill");
      check("sat.score254", score, 254);
      check("sat.streak15", streak, 15);
      play(16'd21920, 1, 1, "sat_perf");
      check("sat.score255", score, 255);
      play(16'd21000, 1, 0, "sat_hold");
      check("sat.hold255", score, 255);
      check("sat.streak_hold", streak, 15);

      // Asynchronous reset while armed.
      round_start = 1'b1;
      @(negedge clk);
      round_start = 1'b0;
      check("rst.armed_before", armed, 1);
      resetn = 1'b0;
      #1;
      check_zero("rst_mid");
      @(negedge clk);
      resetn = 1'b1;
      exp_score = 0; exp_streak = 0; exp_best = 0;
      kick = 1'b1;
      pulses = 0;
      repeat (8) begin
         @(negedge clk);
         if (hit || miss) pulses++;
      end
      check("rst.no_pulse", pulses, 0);
      check("rst.armed_after", armed, 0);
      kick = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
